// File: rtl/reg_file_dw.sv
// Purpose: MSP430 register file with 16 registers (R0 PC, R1 SP, R2 SR/CG1, R3 CG2), two write ports and constant generators.
// Latency: port A/B/shadow writes are visible next cycle; reads are combinational (0 cycles with BYPASS=1 for port A data).
// Backpressure: none; every write request is accepted or resolved by fixed priority in the same cycle.
// Ports: clk/rst (sync, active-low); RW/BW/reg_DA/reg_Din = port A write;
//        inc_en/inc_addr/inc_step = port B (autoinc/dec); reg_*_in = shadow loads for R0..R2;
//        reg_SA/As/Sout = source read with constant generator; reg_DA/Dout = destination read;
//        reg_PC/SP/SR_out = raw R0..R2; pc_fault/collide = registered one-cycle pulses.
module reg_file_dw #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PC_MIN = 'h0200,
  parameter int unsigned BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RW,
  input  logic              BW,
  input  logic [1:0]        As,
  input  logic [3:0]        reg_SA,
  input  logic [3:0]        reg_DA,
  input  logic [DATA_W-1:0] reg_Din,
  input  logic              inc_en,
  input  logic [3:0]        inc_addr,
  input  logic [1:0]        inc_step,
  input  logic [DATA_W-1:0] reg_PC_in,
  input  logic [DATA_W-1:0] reg_SP_in,
  input  logic [DATA_W-1:0] reg_SR_in,
  input  logic [DATA_W-1:0] RST_VEC,
  output logic [DATA_W-1:0] Sout,
  output logic [DATA_W-1:0] Dout,
  output logic [DATA_W-1:0] reg_PC_out,
  output logic [DATA_W-1:0] reg_SP_out,
  output logic [DATA_W-1:0] reg_SR_out,
  output logic              pc_fault,
  output logic              collide
);

  localparam logic [DATA_W-1:0] PC_MIN_W = DATA_W'(PC_MIN);

  logic [DATA_W-1:0] regs_q [16];
  logic [DATA_W-1:0] regs_d [16];
  logic              pc_fault_q, pc_fault_d;
  logic              collide_q, collide_d;

  logic [DATA_W-1:0] wr_val;
  logic [DATA_W-1:0] step_val;
  logic [DATA_W-1:0] sout_val;
  logic [DATA_W-1:0] dout_val;
  logic              wr_a;
  logic              inc_ok;
  logic              pc_bad;
  logic              sa_const;

  // Port A data after byte masking; PC writes are always word aligned.
  always_comb begin
    wr_val = BW ? {{(DATA_W-8){1'b0}}, reg_Din[7:0]} : reg_Din;
    if (reg_DA == 4'd0) wr_val[0] = 1'b0;
  end

  // R3 is the constant generator: it is never a write target.
  assign wr_a   = RW && (reg_DA != 4'd3);
  // SR and CG2 cannot be autoincremented.
  assign inc_ok = inc_en && (inc_addr != 4'd2) && (inc_addr != 4'd3);
  assign pc_bad = wr_a && (reg_DA == 4'd0) && (wr_val < PC_MIN_W);

  always_comb begin
    case (inc_step)
      2'b00:   step_val = DATA_W'(1);
      2'b01:   step_val = DATA_W'(2);
      2'b10:   step_val = {DATA_W{1'b1}} - DATA_W'(1); // two's complement -2
      default: step_val = DATA_W'(4);
    endcase
  end

  // Priority per register: port A > port B > shadow input > hold.
  always_comb begin
    for (int i = 0; i < 16; i++) regs_d[i] = regs_q[i];
    regs_d[0] = reg_PC_in;
    regs_d[1] = reg_SP_in;
    regs_d[2] = reg_SR_in;
    for (int i = 0; i < 16; i++) begin
      if (inc_ok && (inc_addr == 4'(i))) regs_d[i] = regs_q[i] + step_val;
      if (wr_a && (reg_DA == 4'(i)))     regs_d[i] = (i == 0 && pc_bad) ? RST_VEC : wr_val;
    end
  end

  assign pc_fault_d = pc_bad;
  assign collide_d  = wr_a && inc_ok && (inc_addr == reg_DA);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= (i == 0) ? RST_VEC : '0;
      pc_fault_q <= 1'b0;
      collide_q  <= 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) regs_q[i] <= regs_d[i];
      pc_fault_q <= pc_fault_d;
      collide_q  <= collide_d;
    end
  end

  // Source read: R2 with As!=0 and all of R3 are constant-generator reads,
  // which are never forwarded from port A.
  assign sa_const = (reg_SA == 4'd3) || ((reg_SA == 4'd2) && (As != 2'b00));

  always_comb begin
    sout_val = regs_q[reg_SA];
    if (reg_SA == 4'd3) begin
      case (As)
        2'b00:   sout_val = '0;
        2'b01:   sout_val = DATA_W'(1);
        2'b10:   sout_val = DATA_W'(2);
        default: sout_val = '1;
      endcase
    end else if (reg_SA == 4'd2) begin
      case (As)
        2'b00:   sout_val = regs_q[2];
        2'b01:   sout_val = '0;
        2'b10:   sout_val = DATA_W'(4);
        default: sout_val = DATA_W'(8);
      endcase
    end
    if ((BYPASS != 0) && wr_a && !sa_const && (reg_SA == reg_DA)) sout_val = wr_val;

    // Forwarded PC value is the masked value, before the PC_MIN fault substitution.
    dout_val = (reg_DA == 4'd3) ? '0 : regs_q[reg_DA];
    if ((BYPASS != 0) && wr_a) dout_val = wr_val;
  end

  assign Sout       = sout_val;
  assign Dout       = dout_val;
  assign reg_PC_out = regs_q[0];
  assign reg_SP_out = regs_q[1];
  assign reg_SR_out = regs_q[2];
  assign pc_fault   = pc_fault_q;
  assign collide    = collide_q;

endmodule

// File: tb/tb_reg_file_dw.sv
// Purpose: self-checking bench for reg_file_dw (DATA_W=16, PC_MIN=0x200, BYPASS=1).
// Latency: behavioural model updates on posedge, outputs compared every negedge.
// Backpressure: not applicable.
module tb_reg_file_dw;

  logic        clk = 1'b0;
  logic        rst, RW, BW, inc_en;
  logic [1:0]  As, inc_step;
  logic [3:0]  reg_SA, reg_DA, inc_addr;
  logic [15:0] reg_Din, reg_PC_in, reg_SP_in, reg_SR_in, RST_VEC;
  logic [15:0] Sout, Dout, reg_PC_out, reg_SP_out, reg_SR_out;
  logic        pc_fault, collide;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  reg_file_dw #(.DATA_W(16), .PC_MIN('h0200), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .RW(RW), .BW(BW), .As(As),
    .reg_SA(reg_SA), .reg_DA(reg_DA), .reg_Din(reg_Din),
    .inc_en(inc_en), .inc_addr(inc_addr), .inc_step(inc_step),
    .reg_PC_in(reg_PC_in), .reg_SP_in(reg_SP_in), .reg_SR_in(reg_SR_in),
    .RST_VEC(RST_VEC), .Sout(Sout), .Dout(Dout),
    .reg_PC_out(reg_PC_out), .reg_SP_out(reg_SP_out), .reg_SR_out(reg_SR_out),
    .pc_fault(pc_fault), .collide(collide)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m [16];
  bit          m_fault, m_col;
  logic [15:0] cg3   [4] = '{16'h0000, 16'h0001, 16'h0002, 16'hFFFF};
  logic [15:0] cg2   [4] = '{16'h0000, 16'h0000, 16'h0004, 16'h0008};
  logic [15:0] delta [4] = '{16'h0001, 16'h0002, 16'hFFFE, 16'h0004};

  function automatic logic [15:0] wr_value(input logic bw, input logic [3:0] da, input logic [15:0] din);
    logic [15:0] v;
    v = bw ? {8'h00, din[7:0]} : din;
    if (da == 4'd0) v = v & 16'hFFFE;
    return v;
  endfunction

  always @(posedge clk) begin : model
    logic [15:0] nm [16];
    logic [15:0] v;
    bit          inc_v;
    if (!rst) begin
      for (int i = 0; i < 16; i++) nm[i] = 16'h0000;
      nm[0]   = RST_VEC;
      m_fault = 1'b0;
      m_col   = 1'b0;
    end else begin
      nm      = m;
      nm[0]   = reg_PC_in;
      nm[1]   = reg_SP_in;
      nm[2]   = reg_SR_in;
      m_fault = 1'b0;
      m_col   = 1'b0;
      inc_v   = inc_en && inc_addr != 4'd2 && inc_addr != 4'd3;
      if (inc_v) nm[inc_addr] = m[inc_addr] + delta[inc_step];
      if (RW && reg_DA != 4'd3) begin
        v = wr_value(BW, reg_DA, reg_Din);
        if (reg_DA == 4'd0 && v < 16'h0200) begin
          v       = RST_VEC;
          m_fault = 1'b1;
        end
        nm[reg_DA] = v;
        if (inc_v && inc_addr == reg_DA) m_col = 1'b1;
      end
    end
    m = nm;
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [15:0] es, ed;
    if (chk_en) begin
      if (reg_SA == 4'd3)                      es = cg3[As];
      else if (reg_SA == 4'd2 && As != 2'b00)  es = cg2[As];
      else if (RW && reg_DA != 4'd3 && reg_DA == reg_SA) es = wr_value(BW, reg_DA, reg_Din);
      else                                     es = m[reg_SA];
      if (reg_DA == 4'd3) ed = 16'h0000;
      else if (RW)        ed = wr_value(BW, reg_DA, reg_Din);
      else                ed = m[reg_DA];
      chk("Sout", Sout, es);
      chk("Dout", Dout, ed);
      chk("PC", reg_PC_out, m[0]);
      chk("SP", reg_SP_out, m[1]);
      chk("SR", reg_SR_out, m[2]);
      chk("pc_fault", {15'd0, pc_fault}, {15'd0, m_fault});
      chk("collide", {15'd0, collide}, {15'd0, m_col});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RW = 0; BW = 0; inc_en = 0; inc_addr = 4'd4; inc_step = 2'b00;
    As = 2'b00; reg_SA = 4'd4; reg_DA = 4'd4; reg_Din = 16'h0000;
  endtask

  initial begin
    rst = 1'b0; RST_VEC = 16'hC000;
    reg_PC_in = 16'hC000; reg_SP_in = 16'h0000; reg_SR_in = 16'h0000;
    idle();
    // 1. reset values
    tick();
    rst = 1'b1;
    chk_en = 1'b1;
    chk("rst_PC", reg_PC_out, 16'hC000);
    chk("rst_SP", reg_SP_out, 16'h0000);
    chk("rst_SR", reg_SR_out, 16'h0000);
    chk("rst_R4", Dout, 16'h0000);
    chk("rst_flags", {14'd0, pc_fault, collide}, 16'h0000);

    // 2. byte write with bypass
    RW = 1; BW = 1; reg_DA = 4'd5; reg_Din = 16'hABCD; reg_SA = 4'd5;
    #1;
    chk("byp_Sout", Sout, 16'h00CD);
    tick();
    idle(); reg_DA = 4'd5; #1;
    chk("R5_byte", Dout, 16'h00CD);

    // 3. PC faults and aligned PC write
    RW = 1; reg_DA = 4'd0; reg_Din = 16'h0100; #1;
    chk("pc_byp_prefault", Dout, 16'h0100);
    tick();
    chk("pc_fault_vec", reg_PC_out, 16'hC000);
    chk("pc_fault_1", {15'd0, pc_fault}, 16'h0001);
    reg_Din = 16'hC003;
    tick();
    chk("pc_align", reg_PC_out, 16'hC002);
    chk("pc_fault_0", {15'd0, pc_fault}, 16'h0000);

    // 4. autodecrement wrap then +4
    idle(); RW = 1; reg_DA = 4'd6; reg_Din = 16'h0000;
    tick();
    idle(); inc_en = 1; inc_addr = 4'd6; inc_step = 2'b10;
    tick();
    inc_en = 0; reg_DA = 4'd6; #1;
    chk("R6_dec_wrap", Dout, 16'hFFFE);
    inc_en = 1; inc_step = 2'b11;
    tick();
    inc_en = 0; #1;
    chk("R6_inc4", Dout, 16'h0002);

    // 5. port collision
    idle(); RW = 1; reg_DA = 4'd7; reg_Din = 16'h1234; inc_en = 1; inc_addr = 4'd7;
    tick();
    chk("collide_1", {15'd0, collide}, 16'h0001);
    idle(); reg_DA = 4'd7; #1;
    chk("R7_portA_wins", Dout, 16'h1234);
    tick();
    chk("collide_0", {15'd0, collide}, 16'h0000);

    // 6. constant generators, then reset during a write
    reg_SA = 4'd3;
    for (int a = 0; a < 4; a++) begin
      As = 2'(a); #1;
      chk("cg3", Sout, cg3[a]);
    end
    reg_SA = 4'd2; As = 2'b10; #1;
    chk("cg2_4", Sout, 16'h0004);
    idle(); RW = 1; reg_DA = 4'd8; reg_Din = 16'h5555; inc_en = 1; inc_addr = 4'd1;
    reg_SP_in = 16'h7777; rst = 1'b0;
    tick();
    rst = 1'b1; idle(); reg_DA = 4'd8; reg_SP_in = 16'h0000; #1;
    chk("rst_wins_R8", Dout, 16'h0000);
    chk("rst_wins_SP", reg_SP_out, 16'h0000);
    chk("rst_wins_PC", reg_PC_out, 16'hC000);

    // randomized phase, model-checked every cycle
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 59) != 0);
      RW        = 1'($urandom_range(0, 1));
      BW        = ($urandom_range(0, 3) == 0);
      As        = 2'($urandom);
      reg_SA    = 4'($urandom);
      reg_DA    = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      reg_Din   = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h03FF));
      inc_en    = 1'($urandom_range(0, 1));
      inc_addr  = ($urandom_range(0, 2) == 0) ? reg_DA : 4'($urandom);
      inc_step  = 2'($urandom);
      reg_PC_in = 16'($urandom);
      reg_SP_in = 16'($urandom);
      reg_SR_in = 16'($urandom);
      if ($urandom_range(0, 99) == 0) RST_VEC = 16'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
